// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared constants, types and the address legality helper for
//                the data-memory arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

    // Default data memory depth in 32-bit words
    localparam int unsigned c_mem_words_default = 1024;

    // Requester port indices
    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    // Registered state of the response owed on the cycle after a handshake
    typedef struct packed {
        logic pending;
        logic owner;
        logic err;
        logic is_read;
    } rsp_state_t;

    // A byte address is illegal when misaligned or beyond the last word
    function automatic logic addr_is_illegal(input logic [31:0] addr,
                                             input int unsigned mem_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= mem_words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_addr_check.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_addr_check
//  Description : Combinational legality check of a request byte address
//                (alignment and range against the memory depth).
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_addr_check
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = c_mem_words_default
) (
    input  logic [31:0] addr,
    output logic        illegal
);

    assign illegal = addr_is_illegal(addr, MEM_WORDS);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port data-memory arbiter. Port 0 (pipeline) has fixed
//                priority; port 1 (debug/DMA) is promoted once it has waited
//                STARVE_LIMIT cycles. Single-cycle memory access, responses
//                one cycle after the handshake, illegal addresses answered
//                with an error and no memory strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int          STARVE_LIMIT = 4,
    parameter int unsigned MEM_WORDS    = c_mem_words_default
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_valid,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_ready,
    output logic        p0_rsp_valid,
    output logic        p0_rsp_err,
    output logic [31:0] p0_rdata,

    input  logic        p1_valid,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_ready,
    output logic        p1_rsp_valid,
    output logic        p1_rsp_err,
    output logic [31:0] p1_rdata,

    output logic        mem_readEn,
    output logic        mem_writeEn,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int c_cnt_w = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIMIT);

    logic [c_cnt_w-1:0] r_starve_cnt;
    rsp_state_t         r_rsp;

    logic        w_starved;
    logic        w_grant_p0;
    logic        w_grant_p1;
    logic        w_fire;
    logic        w_sel;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_illegal;

    // Grant: p0 by default, p1 when p0 is idle or p1 has waited long enough
    always_comb begin
        w_starved  = (r_starve_cnt == c_starve_max);
        w_grant_p1 = !rst && p1_valid && (!p0_valid || w_starved);
        w_grant_p0 = !rst && p0_valid && !w_grant_p1;
        w_fire     = w_grant_p0 || w_grant_p1;
        w_sel      = w_grant_p1 ? P1 : P0;
        w_we       = (w_sel == P1) ? p1_we    : p0_we;
        w_addr     = (w_sel == P1) ? p1_addr  : p0_addr;
        w_wdata    = (w_sel == P1) ? p1_wdata : p0_wdata;
    end

    assign p0_ready = w_grant_p0;
    assign p1_ready = w_grant_p1;

    dmem_addr_check #(
        .MEM_WORDS (MEM_WORDS)
    ) u_addr_check (
        .addr    (w_addr),
        .illegal (w_illegal)
    );

    // Memory strobes only for an accepted, legal request
    always_comb begin
        mem_readEn  = w_fire && !w_we && !w_illegal;
        mem_writeEn = w_fire &&  w_we && !w_illegal;
        mem_address = {2'b00, w_addr[31:2]};
        mem_wdata   = w_wdata;
    end

    // Count cycles p1 waits; saturate at the limit, clear when p1 is served
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_grant_p1) begin
            r_starve_cnt <= '0;
        end else if (p1_valid && (r_starve_cnt != c_starve_max)) begin
            r_starve_cnt <= r_starve_cnt + c_cnt_w'(1);
        end
    end

    // Remember who is owed a response next cycle and what kind it is
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp <= '0;
        end else begin
            r_rsp.pending <= w_fire;
            r_rsp.owner   <= w_sel;
            r_rsp.err     <= w_illegal;
            r_rsp.is_read <= !w_we;
        end
    end

    // Route the response to its owner; data is zero unless a legal read
    always_comb begin
        p0_rsp_valid = 1'b0;
        p0_rsp_err   = 1'b0;
        p0_rdata     = '0;
        p1_rsp_valid = 1'b0;
        p1_rsp_err   = 1'b0;
        p1_rdata     = '0;
        if (!rst && r_rsp.pending) begin
            if (r_rsp.owner == P0) begin
                p0_rsp_valid = 1'b1;
                p0_rsp_err   = r_rsp.err;
                p0_rdata     = (!r_rsp.err && r_rsp.is_read) ? mem_rdata : '0;
            end else begin
                p1_rsp_valid = 1'b1;
                p1_rsp_err   = r_rsp.err;
                p1_rdata     = (!r_rsp.err && r_rsp.is_read) ? mem_rdata : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter: per-port request
//                queues, a behavioural memory, and a scoreboard of expected
//                responses checked one cycle after each handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int c_limit = 4;
    localparam int c_words = 1024;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          idle;
    } req_t;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_valid, p0_we, p0_ready, p0_rsp_valid, p0_rsp_err;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_valid, p1_we, p1_ready, p1_rsp_valid, p1_rsp_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        mem_readEn, mem_writeEn;
    logic [31:0] mem_address, mem_wdata, mem_rdata;

    logic [1:0]  d_valid = '0;
    logic [1:0]  d_we = '0;
    logic [31:0] d_addr [2];
    logic [31:0] d_wdata [2];
    logic [1:0]  have_item = '0;
    logic [1:0]  hs = '0;
    int          wait_cnt [2];
    req_t        cur [2];

    req_t        q0 [$];
    req_t        q1 [$];
    rsp_t        exp_q [$];

    logic [31:0] fake_mem [c_words];
    logic [31:0] ref_mem [c_words];
    int          m_starve = 0;

    int n_checks = 0;
    int n_fail   = 0;

    assign p0_valid = d_valid[0];
    assign p0_we    = d_we[0];
    assign p0_addr  = d_addr[0];
    assign p0_wdata = d_wdata[0];
    assign p1_valid = d_valid[1];
    assign p1_we    = d_we[1];
    assign p1_addr  = d_addr[1];
    assign p1_wdata = d_wdata[1];

    dmem_arbiter #(
        .STARVE_LIMIT (c_limit),
        .MEM_WORDS    (c_words)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .p0_valid     (p0_valid),
        .p0_we        (p0_we),
        .p0_addr      (p0_addr),
        .p0_wdata     (p0_wdata),
        .p0_ready     (p0_ready),
        .p0_rsp_valid (p0_rsp_valid),
        .p0_rsp_err   (p0_rsp_err),
        .p0_rdata     (p0_rdata),
        .p1_valid     (p1_valid),
        .p1_we        (p1_we),
        .p1_addr      (p1_addr),
        .p1_wdata     (p1_wdata),
        .p1_ready     (p1_ready),
        .p1_rsp_valid (p1_rsp_valid),
        .p1_rsp_err   (p1_rsp_err),
        .p1_rdata     (p1_rdata),
        .mem_readEn   (mem_readEn),
        .mem_writeEn  (mem_writeEn),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEADBEEF : ((i * 32'h01010101) ^ 32'h5A5A0000);
    endfunction

    // Behavioural single-cycle memory; garbage on rdata when not reading
    initial begin
        for (int i = 0; i < c_words; i++) fake_mem[i] = init_word(i);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_writeEn && mem_address < c_words) fake_mem[mem_address[9:0]] <= mem_wdata;
            if (mem_readEn && mem_address < c_words) mem_rdata <= fake_mem[mem_address[9:0]];
            else mem_rdata <= $urandom;
        end
    end

    task automatic push_req(input int p, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int idle);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.idle = idle;
        if (p == 0) q0.push_back(r);
        else        q1.push_back(r);
    endtask

    // Requester model: hold the request until accepted, then move to the next
    task automatic drive_port(input int p);
        if (d_valid[p] && hs[p]) d_valid[p] = 1'b0;
        if (!d_valid[p] && !have_item[p]) begin
            if (p == 0 && q0.size() > 0) begin
                cur[p] = q0.pop_front(); have_item[p] = 1'b1; wait_cnt[p] = cur[p].idle;
            end else if (p == 1 && q1.size() > 0) begin
                cur[p] = q1.pop_front(); have_item[p] = 1'b1; wait_cnt[p] = cur[p].idle;
            end
        end
        if (!d_valid[p] && have_item[p]) begin
            if (wait_cnt[p] == 0) begin
                d_we[p] = cur[p].we; d_addr[p] = cur[p].addr; d_wdata[p] = cur[p].wdata;
                d_valid[p] = 1'b1; have_item[p] = 1'b0;
            end else begin
                wait_cnt[p]--;
            end
        end
    endtask

    initial begin
        d_addr[0] = '0; d_addr[1] = '0; d_wdata[0] = '0; d_wdata[1] = '0;
        forever begin
            @(posedge clk); #1;
            drive_port(0);
            drive_port(1);
        end
    end

    // Monitor: check responses against the scoreboard, grants and strobes
    // against the reference arbitration model, then push new expectations
    initial begin
        rsp_t        e;
        logic        have_e, ex_r0, ex_r1, bad, we;
        logic [31:0] a, wd;
        int          gp;
        for (int i = 0; i < c_words; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            have_e = 1'b0;
            e = '{port: 0, err: 1'b0, rdata: 32'h0};
            if (rst) exp_q.delete();
            else if (exp_q.size() > 0) begin e = exp_q.pop_front(); have_e = 1'b1; end
            chk("p0_rsp_valid", p0_rsp_valid, have_e && e.port == 0);
            chk("p0_rsp_err",   p0_rsp_err,   have_e && e.port == 0 && e.err);
            chk("p0_rdata",     p0_rdata,     (have_e && e.port == 0) ? e.rdata : 32'h0);
            chk("p1_rsp_valid", p1_rsp_valid, have_e && e.port == 1);
            chk("p1_rsp_err",   p1_rsp_err,   have_e && e.port == 1 && e.err);
            chk("p1_rdata",     p1_rdata,     (have_e && e.port == 1) ? e.rdata : 32'h0);

            ex_r1 = !rst && p1_valid && (!p0_valid || m_starve == c_limit);
            ex_r0 = !rst && p0_valid && !ex_r1;
            chk("p0_ready", p0_ready, ex_r0);
            chk("p1_ready", p1_ready, ex_r1);
            gp = ex_r1 ? 1 : (ex_r0 ? 0 : -1);
            if (gp >= 0) begin
                a   = (gp == 1) ? p1_addr  : p0_addr;
                wd  = (gp == 1) ? p1_wdata : p0_wdata;
                we  = (gp == 1) ? p1_we    : p0_we;
                bad = (a[1:0] != 2'b00) || (a[31:2] >= 30'(c_words));
                if (bad) begin
                    chk("err_no_rd", mem_readEn, 1'b0);
                    chk("err_no_wr", mem_writeEn, 1'b0);
                    exp_q.push_back('{port: gp, err: 1'b1, rdata: 32'h0});
                end else begin
                    chk("mem_readEn", mem_readEn, !we);
                    chk("mem_writeEn", mem_writeEn, we);
                    chk("mem_address", mem_address, {22'h0, a[11:2]});
                    if (we) begin
                        chk("mem_wdata", mem_wdata, wd);
                        ref_mem[a[11:2]] = wd;
                        exp_q.push_back('{port: gp, err: 1'b0, rdata: 32'h0});
                    end else begin
                        exp_q.push_back('{port: gp, err: 1'b0, rdata: ref_mem[a[11:2]]});
                    end
                end
            end else begin
                chk("idle_rd", mem_readEn, 1'b0);
                chk("idle_wr", mem_writeEn, 1'b0);
            end
            hs[0] = p0_valid && p0_ready;
            hs[1] = p1_valid && p1_ready;
            if (rst) m_starve = 0;
            else if (ex_r1) m_starve = 0;
            else if (p1_valid && m_starve < c_limit) m_starve++;
        end
    end

    task automatic wait_drain();
        int   n = 0;
        logic done = 1'b0;
        while (!done && n < 500) begin
            @(negedge clk); #2;
            n++;
            done = (q0.size() == 0) && (q1.size() == 0) && (have_item == 2'b00) &&
                   (d_valid == 2'b00) && (exp_q.size() == 0);
        end
        chk("drain", {31'h0, done}, 32'd1);
    endtask

    initial begin
        int   n;
        logic [31:0] ra;
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        int          r;
        logic [31:0] ra;
        rst = 1'b1;
        // Read of word 4 presented during reset; first accept once rst drops
        push_req(0, 1'b0, 32'h10, 32'h0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        wait_drain();

        // Both ports contending: p0 for four cycles, then p1 promoted
        for (int i = 0; i < 6; i++) begin
            push_req(0, 1'b0, 32'(i * 4 + 32'h100), 32'h0, 0);
            push_req(1, 1'b0, 32'(i * 4 + 32'h200), 32'h0, 0);
        end
        wait_drain();

        // Misaligned and out-of-range accesses, plus last legal word
        push_req(1, 1'b1, 32'h1002, 32'h11112222, 0);
        wait_drain();
        push_req(0, 1'b1, 32'h1000, 32'h33334444, 0);
        wait_drain();
        push_req(0, 1'b1, 32'hFFC, 32'h55556666, 0);
        push_req(0, 1'b0, 32'hFFC, 32'h0, 0);
        wait_drain();

        // Alternating p0 writes and p1 reads, one handshake every cycle
        push_req(1, 1'b0, 32'h300, 32'h0, 1);
        for (int i = 0; i < 6; i++) begin
            push_req(0, 1'b1, 32'(i * 4 + 32'h300), 32'(32'hA0000000 + i), (i == 0) ? 0 : 1);
            if (i > 0) push_req(1, 1'b0, 32'(i * 4 + 32'h2FC), 32'h0, 1);
        end
        wait_drain();

        // Reset the cycle after a read handshake drops the response
        push_req(0, 1'b0, 32'h40, 32'h0, 0);
        n = 0;
        while (!hs[0] && n < 50) begin @(negedge clk); #2; n++; end
        chk("rst_hs_seen", {31'h0, hs[0]}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        push_req(0, 1'b0, 32'h40, 32'h0, 0);
        wait_drain();

        // Random traffic on both ports
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 30; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      ra = 32'h1000 + 32'($urandom_range(0, 15) * 4);
                else if (r == 1) ra = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
                else if (r == 2) ra = 32'hFFC;
                else             ra = 32'($urandom_range(0, 63) * 4);
                push_req(p, 1'($urandom_range(0, 1)), ra, $urandom, $urandom_range(0, 2));
            end
        end
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
